// File: rtl/traf_pkg.sv
// Shared definitions for the traffic phase scheduler and the light sequencer:
// phase codes, dwell lengths, FSM encoding and the fixed phase-order rule.
package traf_pkg;

  typedef enum logic [2:0] {
    MAIN_GO   = 3'd0,
    MAIN_TURN = 3'd1,
    SIDE_GO   = 3'd2,
    WALK_MAIN = 3'd3,
    WALK_SIDE = 3'd4
  } phase_e;

  typedef enum logic [1:0] {
    START     = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    NEXT      = 2'd3
  } state_e;

  localparam int unsigned DWELL_MAIN = 6;
  localparam int unsigned DWELL_TURN = 3;
  localparam int unsigned DWELL_SIDE = 4;
  localparam int unsigned DWELL_WALK = 5;

  function automatic int unsigned dwell_of(phase_e p);
    case (p)
      MAIN_GO:   return DWELL_MAIN;
      MAIN_TURN: return DWELL_TURN;
      SIDE_GO:   return DWELL_SIDE;
      default:   return DWELL_WALK;
    endcase
  endfunction

  // pend = {walk_ss, walk_ms, turn}; ptr selects WALK_SIDE when both walks wait.
  function automatic phase_e next_phase(phase_e cur, logic [2:0] pend, logic ptr);
    case (cur)
      MAIN_GO:   return pend[0] ? MAIN_TURN : SIDE_GO;
      MAIN_TURN: return SIDE_GO;
      SIDE_GO: begin
        if (pend[2:1] == 2'b11) return ptr ? WALK_SIDE : WALK_MAIN;
        else if (pend[1])       return WALK_MAIN;
        else if (pend[2])       return WALK_SIDE;
        else                    return MAIN_GO;
      end
      default:   return MAIN_GO;
    endcase
  endfunction

endpackage

// File: rtl/traf_sched_if.sv
// Bundle of sensor, handshake and phase-offer signals between the scheduler
// and its environment (sensors plus light sequencer).
interface traf_sched_if #(parameter int DW = 6) ();

  // Offer handshake: phase/dwell are stable while phase_valid is high; the
  // offer is taken on the cycle phase_valid & phase_ack; phase_done later
  // reports the dwell has expired.
  logic          turn_sensor;
  logic          walk_ms_sensor;
  logic          walk_ss_sensor;
  logic          phase_ack;
  logic          phase_done;
  logic [2:0]    phase;
  logic          phase_valid;
  logic [DW-1:0] dwell;
  logic [2:0]    pend;

  modport master (
    input  turn_sensor, walk_ms_sensor, walk_ss_sensor, phase_ack, phase_done,
    output phase, phase_valid, dwell, pend
  );

  modport slave (
    output turn_sensor, walk_ms_sensor, walk_ss_sensor, phase_ack, phase_done,
    input  phase, phase_valid, dwell, pend
  );

endinterface

// File: rtl/traf_req_latch.sv
// Sticky request bit: set on set_i, cleared on clr_i, set wins when both.
module traf_req_latch (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic set_i,
  input  logic clr_i,
  output logic q_o
);

  logic q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr_i) q_d = 1'b0;
    if (set_i) q_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q_q <= 1'b0;
    else         q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/traf_sched.sv
// Traffic phase scheduler: latches demands and offers one phase at a time to
// the light sequencer in a fixed order with round-robin walk selection.
module traf_sched
  import traf_pkg::*;
#(
  parameter int DW = 6
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          TURN_SENSOR,
  input  logic          WALK_MS_SENSOR,
  input  logic          WALK_SS_SENSOR,
  input  logic          PHASE_ACK,
  input  logic          PHASE_DONE,
  output logic [2:0]    PHASE,
  output logic          PHASE_VALID,
  output logic [DW-1:0] DWELL,
  output logic [2:0]    PEND,
  output logic [1:0]    DBG_STATE
);

  state_e        state_q, state_d;
  phase_e        phase_q, phase_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic          ptr_q;
  logic          ack_fire;
  logic [2:0]    pend;
  logic [2:0]    clr;

  traf_req_latch u_turn (.clk_i(CLK), .rst_ni(RST), .set_i(TURN_SENSOR),
                         .clr_i(clr[0]), .q_o(pend[0]));
  traf_req_latch u_walk_ms (.clk_i(CLK), .rst_ni(RST), .set_i(WALK_MS_SENSOR),
                            .clr_i(clr[1]), .q_o(pend[1]));
  traf_req_latch u_walk_ss (.clk_i(CLK), .rst_ni(RST), .set_i(WALK_SS_SENSOR),
                            .clr_i(clr[2]), .q_o(pend[2]));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= START;
      phase_q <= MAIN_GO;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      dwell_q <= dwell_d;
    end
  end

  // Phase and dwell are only reloaded on entry to ISSUE so they hold steady
  // for the whole offer.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    dwell_d = dwell_q;
    case (state_q)
      START: begin
        state_d = ISSUE;
        phase_d = MAIN_GO;
        dwell_d = DW'(dwell_of(MAIN_GO));
      end
      ISSUE:     if (PHASE_ACK)  state_d = WAIT_DONE;
      WAIT_DONE: if (PHASE_DONE) state_d = NEXT;
      NEXT: begin
        state_d = ISSUE;
        phase_d = next_phase(phase_q, pend, ptr_q);
        dwell_d = DW'(dwell_of(phase_d));
      end
      default:   state_d = START;
    endcase
  end

  always_comb begin
    PHASE_VALID = (state_q == ISSUE);
    PHASE       = phase_q;
    DWELL       = dwell_q;
    PEND        = pend;
    DBG_STATE   = state_q;
  end

  assign ack_fire = PHASE_VALID & PHASE_ACK;

  always_comb begin
    clr = '0;
    if (ack_fire) begin
      case (phase_q)
        MAIN_TURN: clr[0] = 1'b1;
        WALK_MAIN: clr[1] = 1'b1;
        WALK_SIDE: clr[2] = 1'b1;
        default:   clr    = '0;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) ptr_q <= 1'b0;
    else if (ack_fire && (phase_q == WALK_MAIN || phase_q == WALK_SIDE)) ptr_q <= ~ptr_q;
  end

endmodule

// File: tb/tb_traf_sched.sv
// Directed bench for traf_sched: acts as sensors plus light sequencer and
// checks every cycle against a behavioural model of the phase schedule.
module tb_traf_sched;
  import traf_pkg::*;

  localparam int DW = 6;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [1:0] dbg_state;
  bit         turn_hold = 1'b0;
  int         checks = 0;
  int         failures = 0;

  traf_sched_if #(.DW(DW)) tif ();

  traf_sched #(.DW(DW)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .TURN_SENSOR    (tif.turn_sensor),
    .WALK_MS_SENSOR (tif.walk_ms_sensor),
    .WALK_SS_SENSOR (tif.walk_ss_sensor),
    .PHASE_ACK      (tif.phase_ack),
    .PHASE_DONE     (tif.phase_done),
    .PHASE          (tif.phase),
    .PHASE_VALID    (tif.phase_valid),
    .DWELL          (tif.dwell),
    .PEND           (tif.pend),
    .DBG_STATE      (dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: offer pending / waiting for done / rising next edge
  bit         m_valid = 1'b0;
  bit         m_wait = 1'b0;
  bit         m_first = 1'b1;
  bit         m_ptr = 1'b0;
  bit         m_rise = 1'b1;
  bit         m_fire;
  int         m_phase = 0;
  int         m_dwell = 0;
  logic [2:0] m_pend = 3'b000;
  logic [2:0] m_sens;
  logic [2:0] m_clr;
  int         dw_tab[5] = '{6, 3, 4, 5, 5};

  function automatic int m_next(int cur, logic [2:0] p, bit ptr);
    if (cur == 0) return p[0] ? 1 : 2;
    if (cur == 1) return 2;
    if (cur == 2) begin
      if (p[1] && p[2]) return ptr ? 4 : 3;
      if (p[1]) return 3;
      if (p[2]) return 4;
      return 0;
    end
    return 0;
  endfunction

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_valid = 0; m_wait = 0; m_first = 1; m_rise = 1;
      m_ptr = 0; m_phase = 0; m_dwell = 0; m_pend = 3'b000;
    end else begin
      m_sens = {tif.walk_ss_sensor, tif.walk_ms_sensor, tif.turn_sensor};
      m_fire = m_valid && tif.phase_ack;
      m_clr  = 3'b000;
      if (m_fire && m_phase == 1) m_clr = 3'b001;
      if (m_fire && m_phase == 3) m_clr = 3'b010;
      if (m_fire && m_phase == 4) m_clr = 3'b100;
      if (m_fire && m_phase >= 3) m_ptr = !m_ptr;
      if (m_rise) begin
        m_phase = m_first ? 0 : m_next(m_phase, m_pend, m_ptr);
        m_dwell = dw_tab[m_phase];
        m_valid = 1; m_rise = 0; m_first = 0;
      end else if (m_fire) begin
        m_valid = 0; m_wait = 1;
      end else if (m_wait && tif.phase_done) begin
        m_wait = 0; m_rise = 1;
      end
      m_pend = m_sens | (m_pend & ~m_clr);
    end
  end

  // scoreboard compare, every cycle, away from the clock edges
  always @(posedge CLK) begin
    #3;
    chk("cyc_valid", tif.phase_valid, m_valid);
    chk("cyc_phase", tif.phase, m_phase);
    chk("cyc_dwell", tif.dwell, m_dwell);
    chk("cyc_pend",  tif.pend,  m_pend);
  end

  // driver tasks: sequencer side
  task automatic wait_valid(output bit ok);
    int n = 0;
    while (tif.phase_valid !== 1'b1 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    ok = (tif.phase_valid === 1'b1);
    if (!ok) chk("valid_timeout", 0, 1);
  endtask

  task automatic run_phase(input logic [2:0] pulse, input bit early_done,
                           output int ph, output int dw);
    bit ok;
    wait_valid(ok);
    ph = -1; dw = -1;
    if (ok) begin
      ph = int'(tif.phase);
      dw = int'(tif.dwell);
      if (early_done) begin
        tif.phase_done = 1'b1;
        @(negedge CLK);
        tif.phase_done = 1'b0;
        chk("stray_done_state", dbg_state, 32'(ISSUE));
        chk("stray_done_valid", tif.phase_valid, 1);
      end else begin
        @(negedge CLK);
      end
      tif.phase_ack = 1'b1;
      @(negedge CLK);
      tif.phase_ack = 1'b0;
      for (int i = 0; i < dw; i++) begin
        if (i == 0) begin
          tif.turn_sensor    = turn_hold | pulse[0];
          tif.walk_ms_sensor = pulse[1];
          tif.walk_ss_sensor = pulse[2];
        end
        @(negedge CLK);
        tif.turn_sensor    = turn_hold;
        tif.walk_ms_sensor = 1'b0;
        tif.walk_ss_sensor = 1'b0;
      end
      tif.phase_done = 1'b1;
      @(negedge CLK);
      tif.phase_done = 1'b0;
    end
  endtask

  task automatic expect_phase(input string name, input int exp_ph, input int exp_dw,
                              input logic [2:0] pulse, input bit early_done);
    int ph, dw;
    run_phase(pulse, early_done, ph, dw);
    chk({name, "_phase"}, ph, exp_ph);
    chk({name, "_dwell"}, dw, exp_dw);
  endtask

  initial begin
    bit ok;
    tif.turn_sensor = 0; tif.walk_ms_sensor = 0; tif.walk_ss_sensor = 0;
    tif.phase_ack = 0; tif.phase_done = 0;
    #2 RST = 1'b0;
    tif.walk_ms_sensor = 1'b1;
    repeat (2) @(negedge CLK);
    chk("rst_valid", tif.phase_valid, 0);
    chk("rst_phase", tif.phase, 0);
    chk("rst_dwell", tif.dwell, 0);
    chk("rst_pend",  tif.pend, 0);
    chk("rst_state", dbg_state, 32'(START));
    tif.walk_ms_sensor = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("rel_valid", tif.phase_valid, 1);
    chk("rel_phase", tif.phase, 0);

    // idle: 0,2,0,2
    expect_phase("idle0", 0, 6, 3'b000, 0);
    expect_phase("idle1", 2, 4, 3'b000, 0);
    expect_phase("idle2", 0, 6, 3'b000, 0);
    expect_phase("idle3", 2, 4, 3'b000, 0);

    // single turn pulse
    expect_phase("turn0", 0, 6, 3'b001, 0);
    chk("turn_pend_set", tif.pend, 3'b001);
    expect_phase("turn1", 1, 3, 3'b000, 0);
    chk("turn_pend_clr", tif.pend, 3'b000);
    expect_phase("turn2", 2, 4, 3'b000, 0);

    // both walks: 0,2,3,0,2,4,0
    expect_phase("walk0", 0, 6, 3'b110, 0);
    chk("walk_pend_set", tif.pend, 3'b110);
    expect_phase("walk1", 2, 4, 3'b000, 0);
    expect_phase("walk2", 3, 5, 3'b000, 0);
    chk("walk_pend_ms_clr", tif.pend, 3'b100);
    expect_phase("walk3", 0, 6, 3'b000, 0);
    expect_phase("walk4", 2, 4, 3'b000, 0);
    expect_phase("walk5", 4, 5, 3'b000, 0);
    expect_phase("walk6", 0, 6, 3'b000, 0);
    chk("walk_pend_clr", tif.pend, 3'b000);

    // turn sensor held
    turn_hold = 1'b1;
    tif.turn_sensor = 1'b1;
    expect_phase("hold0", 2, 4, 3'b000, 0);
    expect_phase("hold1", 0, 6, 3'b000, 0);
    expect_phase("hold2", 1, 3, 3'b000, 0);
    chk("hold_pend_a", tif.pend[0], 1);
    expect_phase("hold3", 2, 4, 3'b000, 0);
    expect_phase("hold4", 0, 6, 3'b000, 0);
    expect_phase("hold5", 1, 3, 3'b000, 0);
    chk("hold_pend_b", tif.pend[0], 1);
    turn_hold = 1'b0;
    tif.turn_sensor = 1'b0;

    // stray done during ISSUE
    expect_phase("stray0", 2, 4, 3'b000, 1);
    expect_phase("stray1", 0, 6, 3'b000, 0);
    expect_phase("stray2", 1, 3, 3'b000, 0);
    chk("stray_pend", tif.pend, 3'b000);

    // reset while waiting for done on SIDE_GO
    wait_valid(ok);
    chk("mid_phase", tif.phase, 2);
    @(negedge CLK);
    tif.phase_ack = 1'b1;
    @(negedge CLK);
    tif.phase_ack = 1'b0;
    @(negedge CLK);
    chk("mid_state", dbg_state, 32'(WAIT_DONE));
    RST = 1'b0;
    #1;
    chk("mid_rst_valid", tif.phase_valid, 0);
    chk("mid_rst_phase", tif.phase, 0);
    chk("mid_rst_dwell", tif.dwell, 0);
    chk("mid_rst_pend",  tif.pend, 0);
    chk("mid_rst_state", dbg_state, 32'(START));
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("mid_rel_valid", tif.phase_valid, 1);
    chk("mid_rel_phase", tif.phase, 0);
    expect_phase("after0", 0, 6, 3'b000, 0);
    expect_phase("after1", 2, 4, 3'b000, 0);

    repeat (2) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
